// File: rtl/request_priority_encoder.sv
// Sequential 8-to-3 priority encoder with pending-request latching and a valid/ack handshake.
// Define REQ_EDGE_DETECT_EN to capture rising edges instead of levels.
module request_priority_encoder #(
    parameter bit LOW_INDEX_FIRST = 1'b0
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [7:0] Request_Input,
    input  logic       Ack,
    output logic [2:0] Encoder_Output,
    output logic       Valid,
    output logic [7:0] Pending
);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e     state_q, state_d;
    logic [7:0] pending_q, pending_d;
    logic [7:0] capture, set_mask, clr_mask;
    logic [2:0] code_q, code_d;
    logic [2:0] winner;

`ifdef REQ_EDGE_DETECT_EN
    logic [7:0] prev_q;

    // History tracks the raw lines even while capture is frozen.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            prev_q <= 8'h00;
        end else begin
            prev_q <= Request_Input;
        end
    end

    assign capture = Request_Input & ~prev_q;
`else
    assign capture = Request_Input;
`endif

    assign set_mask = Enable ? capture : 8'h00;

    // Scan toward the highest-priority end so the last hit wins.
    always_comb begin : sel_winner
        winner = 3'd0;
        if (LOW_INDEX_FIRST) begin
            for (int i = 7; i >= 0; i--) begin
                if (pending_q[i]) winner = 3'(i);
            end
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (pending_q[i]) winner = 3'(i);
            end
        end
    end

    always_comb begin : fsm_next
        state_d  = state_q;
        code_d   = code_q;
        clr_mask = 8'h00;
        unique case (state_q)
            StIdle: begin
                if (|pending_q) begin
                    code_d  = winner;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (Ack) begin
                    clr_mask = 8'h01 << code_q;
                    state_d  = StIdle;
                end
            end
        endcase
        // A new capture on the retiring bit keeps it pending.
        pending_d = (pending_q & ~clr_mask) | set_mask;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= StIdle;
            pending_q <= 8'h00;
            code_q    <= 3'd0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            code_q    <= code_d;
        end
    end

    assign Encoder_Output = code_q;
    assign Valid          = (state_q == StGrant);
    assign Pending        = pending_q;

endmodule

// File: tb/tb_request_priority_encoder.sv
// Bench for request_priority_encoder: both priority orders side by side, directed scenarios
// plus randomized traffic against a cycle-level reference model.
module tb_request_priority_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en  = 1'b0;
    logic [7:0] req = 8'h00;
    logic       ack = 1'b0;

    logic [2:0] code  [2];
    logic       valid [2];
    logic [7:0] pend  [2];

    int checks = 0;
    int errors = 0;

    // Reference state, index 0 = high-index-first, 1 = low-index-first.
    logic [7:0] m_pend  [2] = '{8'h00, 8'h00};
    logic       m_valid [2] = '{1'b0, 1'b0};
    logic [2:0] m_code  [2] = '{3'd0, 3'd0};
    logic [7:0] m_prev = 8'h00;

    always #5 clk = ~clk;

    request_priority_encoder #(.LOW_INDEX_FIRST(1'b0)) dut_hi (
        .Clock(clk), .Reset(rst), .Enable(en), .Request_Input(req), .Ack(ack),
        .Encoder_Output(code[0]), .Valid(valid[0]), .Pending(pend[0])
    );

    request_priority_encoder #(.LOW_INDEX_FIRST(1'b1)) dut_lo (
        .Clock(clk), .Reset(rst), .Enable(en), .Request_Input(req), .Ack(ack),
        .Encoder_Output(code[1]), .Valid(valid[1]), .Pending(pend[1])
    );

    function automatic logic [2:0] pick(input logic [7:0] p, input bit low_first);
        if (low_first) begin
            for (int i = 0; i < 8; i++) if (p[i]) return 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--) if (p[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    // One clock edge: advance the reference model with the inputs seen at the edge.
    task automatic step();
        logic [7:0] keep, setm, cond;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_pend[k]  = 8'h00;
                m_valid[k] = 1'b0;
                m_code[k]  = 3'd0;
            end else begin
                keep = m_pend[k];
`ifdef REQ_EDGE_DETECT_EN
                cond = req & ~m_prev;
`else
                cond = req;
`endif
                setm = en ? cond : 8'h00;
                if (m_valid[k]) begin
                    if (ack) begin
                        keep[m_code[k]] = 1'b0;
                        m_valid[k] = 1'b0;
                    end
                end else if (m_pend[k] != 8'h00) begin
                    m_code[k]  = pick(m_pend[k], k == 1);
                    m_valid[k] = 1'b1;
                end
                m_pend[k] = keep | setm;
            end
        end
        m_prev = rst ? 8'h00 : req;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; en = 1'b1; ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (valid[k] !== 1'b0) begin
                    errors++; $display("FAIL reset_valid dut%0d got %b want 0", k, valid[k]);
                end
                checks++;
                if (pend[k] !== 8'h00) begin
                    errors++; $display("FAIL reset_pending dut%0d got %h want 00", k, pend[k]);
                end
                checks++;
                if (code[k] !== 3'd0) begin
                    errors++; $display("FAIL reset_code dut%0d got %0d want 0", k, code[k]);
                end
            end
        end
        rst = 1'b0; req = 8'h00;
        step();
    endtask

    task automatic test_priority();
        logic [2:0] first [2]  = '{3'd5, 3'd2};
        logic [2:0] second [2] = '{3'd2, 3'd5};
        req = 8'b0010_0100;
        step();
        req = 8'h00;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== 1'b1 || code[k] !== first[k]) begin
                errors++;
                $display("FAIL prio_first dut%0d got v=%b c=%0d want v=1 c=%0d",
                         k, valid[k], code[k], first[k]);
            end
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== 1'b0) begin
                errors++; $display("FAIL prio_idle_gap dut%0d got v=%b want 0", k, valid[k]);
            end
        end
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== 1'b1 || code[k] !== second[k]) begin
                errors++;
                $display("FAIL prio_second dut%0d got v=%b c=%0d want v=1 c=%0d",
                         k, valid[k], code[k], second[k]);
            end
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== 1'b0 || pend[k] !== 8'h00) begin
                errors++;
                $display("FAIL prio_drain dut%0d got v=%b p=%h want v=0 p=00",
                         k, valid[k], pend[k]);
            end
        end
    endtask

    task automatic test_hold();
        req = 8'h08;
        step();
        req = 8'h00;
        step();
        req = 8'h80;
        step();
        req = 8'h00;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== 1'b1 || code[k] !== 3'd3 || pend[k] !== 8'h88) begin
                errors++;
                $display("FAIL hold_no_preempt dut%0d got v=%b c=%0d p=%h want v=1 c=3 p=88",
                         k, valid[k], code[k], pend[k]);
            end
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== 1'b1 || code[k] !== 3'd7) begin
                errors++;
                $display("FAIL hold_next dut%0d got v=%b c=%0d want v=1 c=7",
                         k, valid[k], code[k]);
            end
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
    endtask

    task automatic test_set_wins();
        req = 8'h10;
        step();
        req = 8'h00;
        step();
        ack = 1'b1; req = 8'h10;
        step();
        ack = 1'b0; req = 8'h00;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (pend[k][4] !== 1'b1 || valid[k] !== 1'b0) begin
                errors++;
                $display("FAIL set_wins_pending dut%0d got p=%h v=%b want p[4]=1 v=0",
                         k, pend[k], valid[k]);
            end
        end
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== 1'b1 || code[k] !== 3'd4) begin
                errors++;
                $display("FAIL set_wins_regrant dut%0d got v=%b c=%0d want v=1 c=4",
                         k, valid[k], code[k]);
            end
        end
        ack = 1'b1;
        step();
        ack = 1'b0;
        step();
    endtask

    task automatic test_enable();
        logic exp_v;
        en = 1'b0; req = 8'h40;
        step();
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (pend[k] !== 8'h00 || valid[k] !== 1'b0) begin
                errors++;
                $display("FAIL enable_frozen dut%0d got p=%h v=%b want p=00 v=0",
                         k, pend[k], valid[k]);
            end
        end
        en = 1'b1;
        step();
        step();
`ifdef REQ_EDGE_DETECT_EN
        exp_v = 1'b0;
`else
        exp_v = 1'b1;
`endif
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== exp_v || (exp_v && code[k] !== 3'd6)) begin
                errors++;
                $display("FAIL enable_resume dut%0d got v=%b c=%0d want v=%b c=6",
                         k, valid[k], code[k], exp_v);
            end
        end
        req = 8'h00; ack = 1'b1;
        step();
        ack = 1'b0;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== 1'b0 || pend[k] !== 8'h00) begin
                errors++;
                $display("FAIL enable_drain dut%0d got v=%b p=%h want v=0 p=00",
                         k, valid[k], pend[k]);
            end
        end
    endtask

    task automatic test_reset_mid_grant();
        req = 8'h02;
        step();
        req = 8'h00;
        step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== 1'b1 || code[k] !== 3'd1) begin
                errors++;
                $display("FAIL rstmid_grant dut%0d got v=%b c=%0d want v=1 c=1",
                         k, valid[k], code[k]);
            end
        end
        // Reset outranks a simultaneous ack and capture.
        rst = 1'b1; ack = 1'b1; req = 8'h02;
        step();
        rst = 1'b0; ack = 1'b0; req = 8'h00;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== 1'b0 || pend[k] !== 8'h00) begin
                errors++;
                $display("FAIL rstmid_abort dut%0d got v=%b p=%h want v=0 p=00",
                         k, valid[k], pend[k]);
            end
        end
        for (int c = 0; c < 3; c++) step();
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (valid[k] !== 1'b0) begin
                errors++; $display("FAIL rstmid_quiet dut%0d got v=%b want 0", k, valid[k]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            req = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            en  = ($urandom_range(0, 7) != 0);
            ack = ($urandom_range(0, 2) != 0);
            rst = ($urandom_range(0, 99) == 0);
            step();
            for (int k = 0; k < 2; k++) begin
                checks++;
                if (valid[k] !== m_valid[k] || code[k] !== m_code[k] || pend[k] !== m_pend[k]) begin
                    errors++;
                    $display("FAIL random cyc%0d dut%0d got v=%b c=%0d p=%h want v=%b c=%0d p=%h",
                             c, k, valid[k], code[k], pend[k], m_valid[k], m_code[k], m_pend[k]);
                end
            end
        end
        rst = 1'b0; en = 1'b1; ack = 1'b0; req = 8'h00;
    endtask

    initial begin
        #2;
        test_reset();
        test_priority();
        test_hold();
        test_set_wins();
        test_enable();
        test_reset_mid_grant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
